// File: rtl/fb_access_arbiter_pkg.sv
// Shared types and constants for the frame-buffer access arbiter.
package fb_access_arbiter_pkg;

    localparam int unsigned PIX_W         = 15;
    localparam int unsigned DEFAULT_DEPTH = 76800;
    localparam int unsigned ID_W          = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } arb_state_e;

endpackage

// File: rtl/fb_access_arbiter_rr_picker.sv
// Combinational round-robin select: first requester after ptr_i, wrapping.
module rr_picker
    import fb_access_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 3
)(
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic               valid_o,
    output logic [ID_W-1:0]    idx_o
);

    logic [ID_W-1:0] cand;

    // Scan from farthest to nearest so the nearest hit after ptr_i wins.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        cand    = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            cand = ID_W'((32'(ptr_i) + 32'(i)) % NUM_REQ);
            if (req_i[cand]) begin
                valid_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/fb_access_arbiter.sv
// Round-robin frame-buffer arbiter with hold timeout and per-client lockout.
module fb_access_arbiter
    import fb_access_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 3,
    parameter int unsigned depth    = DEFAULT_DEPTH,
    parameter int unsigned addrBits = $clog2(depth),
    parameter int unsigned MAX_HOLD = 131072
)(
    input  logic                         sobel_clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           rq,
    output logic [NUM_REQ-1:0]           ack,
    input  logic [NUM_REQ*addrBits-1:0]  cli_addr,
    input  logic [NUM_REQ-1:0]           cli_we,
    input  logic [NUM_REQ*PIX_W-1:0]     cli_wdata,
    output logic [addrBits-1:0]          mem_addr,
    output logic                         mem_we,
    output logic [PIX_W-1:0]             mem_wdata,
    output logic                         mem_en,
    output logic [ID_W-1:0]              grant_id,
    output logic                         timeout_err
);

    localparam int unsigned HOLD_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    arb_state_e        state_q, state_d;
    logic [ID_W-1:0]   grant_id_q, grant_id_d;
    logic [ID_W-1:0]   last_grant_q, last_grant_d;
    logic [NUM_REQ-1:0] mask_q, mask_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              timeout_q, timeout_d;

    logic              pick_valid;
    logic [ID_W-1:0]   pick_idx;
    int unsigned       sel;

    rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req_i   (rq & ~mask_q),
        .ptr_i   (last_grant_q),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    // State and bookkeeping registers, synchronous reset.
    always_ff @(posedge sobel_clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            grant_id_q   <= '0;
            last_grant_q <= ID_W'(NUM_REQ - 1);
            mask_q       <= '0;
            hold_q       <= '0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_id_q   <= grant_id_d;
            last_grant_q <= last_grant_d;
            mask_q       <= mask_d;
            hold_q       <= hold_d;
            timeout_q    <= timeout_d;
        end
    end

    // Next-state: arbitrate in IDLE, hold/timeout in GRANT, one gap cycle in RELEASE.
    always_comb begin
        state_d      = state_q;
        grant_id_d   = grant_id_q;
        last_grant_d = last_grant_q;
        mask_d       = mask_q & rq;      // a low request lifts the lockout
        hold_d       = hold_q;
        timeout_d    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d    = ST_GRANT;
                    grant_id_d = pick_idx;
                    hold_d     = '0;
                end
            end
            ST_GRANT: begin
                if (!rq[grant_id_q]) begin
                    state_d = ST_RELEASE;
                end else if (hold_q == HOLD_LAST) begin
                    state_d            = ST_RELEASE;
                    timeout_d          = 1'b1;
                    mask_d[grant_id_q] = 1'b1;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            ST_RELEASE: begin
                last_grant_d = grant_id_q;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Bus mux: granted client's slice while GRANT, zeros otherwise.
    always_comb begin
        sel         = 32'(grant_id_q);
        mem_en      = (state_q == ST_GRANT);
        ack         = '0;
        mem_addr    = '0;
        mem_wdata   = '0;
        mem_we      = 1'b0;
        if (mem_en) begin
            ack       = NUM_REQ'(1) << grant_id_q;
            mem_addr  = cli_addr[sel*addrBits +: addrBits];
            mem_wdata = cli_wdata[sel*PIX_W +: PIX_W];
            mem_we    = cli_we[grant_id_q];
        end
        grant_id    = grant_id_q;
        timeout_err = timeout_q;
    end

endmodule

// File: tb/tb_fb_access_arbiter.sv
// Directed self-checking bench for fb_access_arbiter.
module tb_fb_access_arbiter;

    localparam int unsigned NR = 3;
    localparam int unsigned AW = 17;
    localparam int unsigned PW = 15;
    localparam int unsigned MH = 16;

    logic              sobel_clk = 1'b0;
    logic              reset;
    logic [NR-1:0]     rq;
    logic [NR-1:0]     ack;
    logic [NR*AW-1:0]  cli_addr;
    logic [NR-1:0]     cli_we;
    logic [NR*PW-1:0]  cli_wdata;
    logic [AW-1:0]     mem_addr;
    logic              mem_we;
    logic [PW-1:0]     mem_wdata;
    logic              mem_en;
    logic [1:0]        grant_id;
    logic              timeout_err;

    int n_checks = 0;
    int n_pass   = 0;

    fb_access_arbiter #(
        .NUM_REQ  (NR),
        .depth    (76800),
        .MAX_HOLD (MH)
    ) dut (
        .sobel_clk   (sobel_clk),
        .reset       (reset),
        .rq          (rq),
        .ack         (ack),
        .cli_addr    (cli_addr),
        .cli_we      (cli_we),
        .cli_wdata   (cli_wdata),
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .mem_en      (mem_en),
        .grant_id    (grant_id),
        .timeout_err (timeout_err)
    );

    always #5 sobel_clk = ~sobel_clk;

    task automatic tick();
        @(posedge sobel_clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        rq    = '0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        rq        = '0;
        cli_we    = '1;
        cli_addr  = {17'h1ABCD, 17'h0F0F0, 17'h12345};
        cli_wdata = {15'h7FFF, 15'h5555, 15'h2AAA};
        tick();
        tick();
        n_checks++; if (ack !== 3'b000) $display("FAIL reset_ack: got %b want 000", ack); else n_pass++;
        n_checks++; if (mem_en !== 1'b0) $display("FAIL reset_mem_en: got %b want 0", mem_en); else n_pass++;
        n_checks++; if (mem_we !== 1'b0) $display("FAIL reset_mem_we: got %b want 0", mem_we); else n_pass++;
        n_checks++; if (mem_addr !== 17'h0) $display("FAIL reset_mem_addr: got %h want 0", mem_addr); else n_pass++;
        n_checks++; if (mem_wdata !== 15'h0) $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); else n_pass++;
        n_checks++; if (grant_id !== 2'd0) $display("FAIL reset_grant_id: got %0d want 0", grant_id); else n_pass++;
        n_checks++; if (timeout_err !== 1'b0) $display("FAIL reset_timeout: got %b want 0", timeout_err); else n_pass++;
        reset = 1'b0;
    endtask

    task automatic test_single();
        int bad;
        apply_reset();
        cli_we        = '0;
        cli_addr[0 +: AW] = 17'h00123;
        rq            = 3'b001;
        tick();
        n_checks++; if (ack !== 3'b001) $display("FAIL single_ack_rise: got %b want 001", ack); else n_pass++;
        n_checks++; if (mem_en !== 1'b1) $display("FAIL single_mem_en: got %b want 1", mem_en); else n_pass++;
        n_checks++; if (grant_id !== 2'd0) $display("FAIL single_grant_id: got %0d want 0", grant_id); else n_pass++;
        n_checks++; if (mem_addr !== 17'h00123) $display("FAIL single_addr: got %h want 00123", mem_addr); else n_pass++;
        cli_addr[0 +: AW] = 17'h0456A;
        #1;
        n_checks++; if (mem_addr !== 17'h0456A) $display("FAIL single_addr_follow: got %h want 0456a", mem_addr); else n_pass++;
        bad = 0;
        for (int c = 2; c <= 10; c++) begin
            tick();
            if (ack !== 3'b001) bad++;
        end
        n_checks++; if (bad != 0) $display("FAIL single_hold: got %0d dropped cycles want 0", bad); else n_pass++;
        rq = 3'b000;
        tick();
        n_checks++; if (ack !== 3'b000) $display("FAIL single_release_ack: got %b want 000", ack); else n_pass++;
        n_checks++; if (mem_en !== 1'b0) $display("FAIL single_release_en: got %b want 0", mem_en); else n_pass++;
        n_checks++; if (timeout_err !== 1'b0) $display("FAIL single_no_timeout: got %b want 0", timeout_err); else n_pass++;
        tick();
        n_checks++; if (ack !== 3'b000) $display("FAIL single_idle_ack: got %b want 000", ack); else n_pass++;
    endtask

    task automatic test_round_robin();
        int exp_order[4];
        logic [NR-1:0] exp_ack;
        exp_order = '{0, 1, 2, 0};
        apply_reset();
        cli_we = '0;
        rq     = 3'b111;
        tick();
        for (int k = 0; k < 4; k++) begin
            exp_ack = 3'b001 << exp_order[k];
            n_checks++; if (ack !== exp_ack) $display("FAIL rr_ack_%0d: got %b want %b", k, ack, exp_ack); else n_pass++;
            n_checks++; if (grant_id !== 2'(exp_order[k])) $display("FAIL rr_id_%0d: got %0d want %0d", k, grant_id, exp_order[k]); else n_pass++;
            rq[exp_order[k]] = 1'b0;
            tick();
            n_checks++; if (ack !== 3'b000 || mem_en !== 1'b0) $display("FAIL rr_release_%0d: got ack %b en %b want 000 0", k, ack, mem_en); else n_pass++;
            rq[exp_order[k]] = 1'b1;
            tick();
            n_checks++; if (ack !== 3'b000) $display("FAIL rr_idle_%0d: got %b want 000", k, ack); else n_pass++;
            if (k < 3) tick();
        end
        rq = '0;
        tick();
        tick();
    endtask

    task automatic test_timeout();
        int acks, pulses, to_cycle;
        apply_reset();
        rq       = 3'b010;
        acks     = 0;
        pulses   = 0;
        to_cycle = 0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (ack[1] === 1'b1) acks++;
            if (timeout_err === 1'b1) begin
                pulses++;
                if (to_cycle == 0) to_cycle = c;
            end
        end
        n_checks++; if (acks != 16) $display("FAIL timeout_ack_cycles: got %0d want 16", acks); else n_pass++;
        n_checks++; if (pulses != 1) $display("FAIL timeout_pulses: got %0d want 1", pulses); else n_pass++;
        n_checks++; if (to_cycle != 17) $display("FAIL timeout_cycle: got %0d want 17", to_cycle); else n_pass++;
        rq = 3'b000;
        tick();
        n_checks++; if (ack !== 3'b000) $display("FAIL timeout_low_ack: got %b want 000", ack); else n_pass++;
        rq = 3'b010;
        tick();
        n_checks++; if (ack !== 3'b010) $display("FAIL timeout_regrant: got %b want 010", ack); else n_pass++;
        rq = 3'b000;
        tick();
        tick();
    endtask

    task automatic test_we_gating();
        apply_reset();
        rq        = 3'b101;
        cli_we    = 3'b100;
        cli_wdata = {15'h7FFF, 15'h3333, 15'h01AB};
        tick();
        n_checks++; if (ack !== 3'b001) $display("FAIL we_grant0: got %b want 001", ack); else n_pass++;
        n_checks++; if (mem_we !== 1'b0) $display("FAIL we_other_client: got %b want 0", mem_we); else n_pass++;
        cli_we = 3'b101;
        #1;
        n_checks++; if (mem_we !== 1'b1) $display("FAIL we_follow0: got %b want 1", mem_we); else n_pass++;
        n_checks++; if (mem_wdata !== 15'h01AB) $display("FAIL we_wdata0: got %h want 01ab", mem_wdata); else n_pass++;
        cli_we = 3'b111;
        rq     = 3'b100;
        tick();
        n_checks++; if (mem_we !== 1'b0 || mem_en !== 1'b0) $display("FAIL we_release: got we %b en %b want 0 0", mem_we, mem_en); else n_pass++;
        n_checks++; if (mem_wdata !== 15'h0) $display("FAIL we_release_wdata: got %h want 0", mem_wdata); else n_pass++;
        tick();
        tick();
        n_checks++; if (ack !== 3'b100) $display("FAIL we_grant2: got %b want 100", ack); else n_pass++;
        n_checks++; if (mem_we !== 1'b1 || mem_wdata !== 15'h7FFF) $display("FAIL we_follow2: got we %b data %h want 1 7fff", mem_we, mem_wdata); else n_pass++;
        rq = 3'b000;
        tick();
        tick();
    endtask

    task automatic test_reset_mid_grant();
        apply_reset();
        cli_we = '1;
        rq     = 3'b001;
        tick();
        rq = 3'b000;
        tick();
        tick();
        rq = 3'b111;
        tick();
        n_checks++; if (ack !== 3'b010) $display("FAIL mid_pre_grant: got %b want 010", ack); else n_pass++;
        for (int c = 2; c <= 5; c++) tick();
        reset = 1'b1;
        tick();
        n_checks++; if (ack !== 3'b000 || mem_en !== 1'b0) $display("FAIL mid_reset_drop: got ack %b en %b want 000 0", ack, mem_en); else n_pass++;
        n_checks++; if (mem_we !== 1'b0 || mem_addr !== 17'h0 || mem_wdata !== 15'h0) $display("FAIL mid_reset_bus: got we %b addr %h data %h want 0 0 0", mem_we, mem_addr, mem_wdata); else n_pass++;
        n_checks++; if (grant_id !== 2'd0 || timeout_err !== 1'b0) $display("FAIL mid_reset_id_to: got id %0d to %b want 0 0", grant_id, timeout_err); else n_pass++;
        reset = 1'b0;
        tick();
        n_checks++; if (ack !== 3'b001) $display("FAIL mid_restart: got %b want 001", ack); else n_pass++;
        rq = 3'b000;
        tick();
        tick();
    endtask

    initial begin
        reset     = 1'b1;
        rq        = '0;
        cli_addr  = '0;
        cli_we    = '0;
        cli_wdata = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_we_gating();
        test_reset_mid_grant();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
